// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus bundle: instruction-cache request/response, predictor
// lookup, instruction-queue push and the commit-side redirect.
interface ifetch_unit_if #(
    parameter int DATA_W = 32
);
    // Instruction cache
    logic              ic_req;
    logic [DATA_W-1:0] ic_addr;
    logic              ic_valid;
    logic [DATA_W-1:0] ic_inst;

    // Branch predictor lookup
    logic [DATA_W-1:0] pred_pc;
    logic              pred_taken;

    // Instruction queue
    logic              iq_full;
    logic              iq_push;
    logic [DATA_W-1:0] iq_inst;
    logic [DATA_W-1:0] iq_pc;
    logic              iq_pred;
    logic [DATA_W-1:0] iq_pred_pc;

    // Commit-side redirect
    logic              redirect_flag;
    logic [DATA_W-1:0] redirect_pc;

    // Fetch unit side
    modport master (
        output ic_req, ic_addr, pred_pc,
        output iq_push, iq_inst, iq_pc, iq_pred, iq_pred_pc,
        input  ic_valid, ic_inst, pred_taken, iq_full,
        input  redirect_flag, redirect_pc
    );

    // Environment side: cache, predictor, queue, commit
    modport slave (
        input  ic_req, ic_addr, pred_pc,
        input  iq_push, iq_inst, iq_pc, iq_pred, iq_pred_pc,
        output ic_valid, ic_inst, pred_taken, iq_full,
        output redirect_flag, redirect_pc
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding cache request at a time, static
// JAL/branch decode combined with the predictor answer to pick the next PC,
// registered push into the instruction queue, and redirect handling that
// drains an in-flight cache request before restarting at the new PC.
module ifetch_unit #(
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    ifetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DRAIN
    } state_t;

    localparam logic [6:0]        OP_JAL     = 7'b1101111;
    localparam logic [6:0]        OP_BRANCH  = 7'b1100011;
    localparam logic [DATA_W-1:0] INST_BYTES = DATA_W'(4);

    // Sign-extended J-type immediate (JAL offset, bit 0 always zero).
    function automatic logic signed [DATA_W-1:0] imm_j(input logic [DATA_W-1:0] i);
        return {{(DATA_W-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate (conditional branch offset).
    function automatic logic signed [DATA_W-1:0] imm_b(input logic [DATA_W-1:0] i);
        return {{(DATA_W-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // Architectural state
    state_t            state, state_d;
    logic [DATA_W-1:0] pc, pc_d;
    // Address actually presented to the cache; stays on the old request
    // while draining after a redirect, so it is kept apart from pc.
    logic [DATA_W-1:0] fetch_addr, fetch_addr_d;

    // Fetched-word buffer (stage p0: waiting for the queue)
    logic [DATA_W-1:0] buf_inst, buf_inst_d;
    logic [DATA_W-1:0] buf_pc, buf_pc_d;

    // Queue push registers (stage p1: presented to the queue)
    logic              iq_vld_p1, iq_vld_d;
    logic [DATA_W-1:0] iq_inst_p1, iq_inst_d;
    logic [DATA_W-1:0] iq_pc_p1, iq_pc_d;
    logic              iq_pred_p1, iq_pred_d;
    logic [DATA_W-1:0] iq_npc_p1, iq_npc_d;

    // Decode result for the buffered word
    logic [6:0]        opcode;
    logic              dec_pred;
    logic [DATA_W-1:0] dec_npc;

    // Static decode of buf_inst combined with the live predictor answer.
    always_comb begin
        opcode   = buf_inst[6:0];
        dec_pred = 1'b0;
        dec_npc  = buf_pc + INST_BYTES;
        if (opcode == OP_JAL) begin
            dec_pred = 1'b1;
            dec_npc  = buf_pc + $unsigned(imm_j(buf_inst));
        end else if (opcode == OP_BRANCH) begin
            dec_pred = bus.pred_taken;
            if (bus.pred_taken) begin
                dec_npc = buf_pc + $unsigned(imm_b(buf_inst));
            end
        end
    end

    // Next-state and next-register computation; redirect outranks everything.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        fetch_addr_d = fetch_addr;
        buf_inst_d   = buf_inst;
        buf_pc_d     = buf_pc;
        iq_vld_d     = 1'b0;
        iq_inst_d    = iq_inst_p1;
        iq_pc_d      = iq_pc_p1;
        iq_pred_d    = iq_pred_p1;
        iq_npc_d     = iq_npc_p1;

        if (bus.redirect_flag) begin
            pc_d = bus.redirect_pc;
            unique case (state)
                S_IDLE, S_ISSUE: begin
                    state_d      = S_FETCH;
                    fetch_addr_d = bus.redirect_pc;
                end
                S_FETCH, S_DRAIN: begin
                    if (bus.ic_valid) begin
                        // The returning word belongs to the old path.
                        state_d      = S_FETCH;
                        fetch_addr_d = bus.redirect_pc;
                    end else begin
                        // Keep the old request up until the cache answers it.
                        state_d = S_DRAIN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_d      = S_FETCH;
                    fetch_addr_d = pc;
                end
                S_FETCH: begin
                    if (bus.ic_valid) begin
                        buf_inst_d = bus.ic_inst;
                        buf_pc_d   = pc;
                        state_d    = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!bus.iq_full) begin
                        iq_vld_d     = 1'b1;
                        iq_inst_d    = buf_inst;
                        iq_pc_d      = buf_pc;
                        iq_pred_d    = dec_pred;
                        iq_npc_d     = dec_npc;
                        pc_d         = dec_npc;
                        fetch_addr_d = dec_npc;
                        state_d      = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (bus.ic_valid) begin
                        state_d      = S_FETCH;
                        fetch_addr_d = pc;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register: every register holds while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            buf_inst   <= '0;
            buf_pc     <= '0;
            iq_vld_p1  <= 1'b0;
            iq_inst_p1 <= '0;
            iq_pc_p1   <= '0;
            iq_pred_p1 <= 1'b0;
            iq_npc_p1  <= '0;
        end else if (rdy) begin
            state      <= state_d;
            pc         <= pc_d;
            fetch_addr <= fetch_addr_d;
            buf_inst   <= buf_inst_d;
            buf_pc     <= buf_pc_d;
            iq_vld_p1  <= iq_vld_d;
            iq_inst_p1 <= iq_inst_d;
            iq_pc_p1   <= iq_pc_d;
            iq_pred_p1 <= iq_pred_d;
            iq_npc_p1  <= iq_npc_d;
        end
    end

    assign bus.ic_req     = (state == S_FETCH) || (state == S_DRAIN);
    assign bus.ic_addr    = fetch_addr;
    assign bus.pred_pc    = buf_pc;
    assign bus.iq_push    = iq_vld_p1;
    assign bus.iq_inst    = iq_inst_p1;
    assign bus.iq_pc      = iq_pc_p1;
    assign bus.iq_pred    = iq_pred_p1;
    assign bus.iq_pred_pc = iq_npc_p1;

endmodule
